// File: rtl/dff_feed_pkg.sv
// Shared types, constants and helpers for dff_feed_fifo and its storage array.
package dff_feed_pkg;

    localparam int unsigned DFF_FEED_DEPTH = 8;
    localparam logic [63:0] DFF_FEED_RST_DATA = '0;

    typedef logic [$clog2(DFF_FEED_DEPTH):0] count_t;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/dff_feed_mem.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, one combinational read port.
module dff_feed_mem
    import dff_feed_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [ptr_w(DEPTH)-1:0]    waddr,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic [ptr_w(DEPTH)-1:0]    raddr,
    output logic [DATA_WIDTH-1:0]      rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dff_feed_fifo.sv
// Synchronous FIFO draining into an enable-gated register stage as a registered (out_en, out_d) pair.
// Optional empty-FIFO write-through path enabled by defining DFF_FEED_FIFO_BYPASS_EN.
module dff_feed_fifo
    import dff_feed_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned AF_THR     = 6
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      wr_en,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic                      rd_ready,
    output logic                      out_en,
    output logic [DATA_WIDTH-1:0]     out_d,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow
);

    localparam int unsigned PW = ptr_w(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  bypass;
    logic                  pop;
    logic                  push;

    assign full        = (count == CW'(DEPTH));
    assign empty       = (count == '0);
    assign almost_full = (count >= CW'(AF_THR));

`ifdef DFF_FEED_FIFO_BYPASS_EN
    assign bypass = empty && wr_en && rd_ready;
`else
    assign bypass = 1'b0;
`endif

    // A pop frees a slot in the same cycle, so a push into a full FIFO is accepted alongside it.
    assign pop  = rd_ready && !empty;
    assign push = wr_en && (!full || pop) && !bypass;

    dff_feed_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            out_en   <= 1'b0;
            out_d    <= DATA_WIDTH'(DFF_FEED_RST_DATA);
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (wr_en && full && !pop) begin
                overflow <= 1'b1;
            end
            if (bypass) begin
                out_en <= 1'b1;
                out_d  <= wr_data;
            end else if (pop) begin
                out_en <= 1'b1;
                out_d  <= rd_data;
            end else begin
                out_en <= 1'b0;
                out_d  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dff_feed_fifo.sv
// Self-checking bench for dff_feed_fifo: queue-based reference model plus directed literal checks.
module tb_dff_feed_fifo;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
`ifdef DFF_FEED_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_ready;
    logic          out_en;
    logic [DW-1:0] out_d;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic [3:0]    count;
    logic          overflow;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    dff_feed_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AF_THR     (AF)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_ready    (rd_ready),
        .out_en      (out_en),
        .out_d       (out_d),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of stored words and the expected registered outputs.
    logic [DW-1:0] q[$];
    bit            m_en;
    logic [DW-1:0] m_d;
    bit            m_ovf;

    always @(posedge clk) begin
        if (!rstn) begin
            q.delete();
            m_en  = 1'b0;
            m_d   = '0;
            m_ovf = 1'b0;
        end else if (BYP && q.size() == 0 && wr_en && rd_ready) begin
            m_en = 1'b1;
            m_d  = wr_data;
        end else begin
            if (rd_ready && q.size() > 0) begin
                m_en = 1'b1;
                m_d  = q.pop_front();
            end else begin
                m_en = 1'b0;
                m_d  = '0;
            end
            if (wr_en) begin
                if (q.size() < DEPTH) q.push_back(wr_data);
                else m_ovf = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_en",      32'(out_en),      32'(m_en));
            check("out_d",       32'(out_d),       32'(m_d));
            check("count",       32'(count),       32'(q.size()));
            check("empty",       32'(empty),       32'(q.size() == 0));
            check("full",        32'(full),        32'(q.size() == DEPTH));
            check("almost_full", 32'(almost_full), 32'(q.size() >= AF));
            check("overflow",    32'(overflow),    32'(m_ovf));
            check("count_bound", 32'(count <= 4'(DEPTH)), 32'd1);
        end
    end

    task automatic drive(input logic w, input logic [DW-1:0] d, input logic r);
        wr_en    = w;
        wr_data  = d;
        rd_ready = r;
    endtask

    task automatic do_reset();
        drive(1'b0, '0, 1'b0);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Idle with rd_ready=1 for n cycles, recording every delivered word.
    task automatic drain(input int n, output logic [DW-1:0] got[$]);
        got.delete();
        drive(1'b0, '0, 1'b1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (out_en) got.push_back(out_d);
        end
    endtask

    initial begin
        logic [DW-1:0] got[$];
        logic [DW-1:0] exp_d[5];
        bit            exp_e[5];

        rstn = 1'b0;
        drive(1'b0, '0, 1'b0);
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rstn = 1'b1;

        // Reset discards stored words
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, DW'(16'h0A00 + i), 1'b0);
            @(negedge clk);
        end
        check("pre_reset_count", 32'(count), 32'd3);
        do_reset();
        check("rst_empty",    32'(empty),    32'd1);
        check("rst_count",    32'(count),    32'd0);
        check("rst_out_en",   32'(out_en),   32'd0);
        check("rst_out_d",    32'(out_d),    32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);

        // Basic order with rd_ready held high
        if (BYP) begin
            exp_e = '{1, 1, 1, 0, 0};
            exp_d = '{16'h1111, 16'h2222, 16'h3333, 16'h0, 16'h0};
        end else begin
            exp_e = '{0, 1, 1, 1, 0};
            exp_d = '{16'h0, 16'h1111, 16'h2222, 16'h3333, 16'h0};
        end
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: drive(1'b1, 16'h1111, 1'b1);
                1: drive(1'b1, 16'h2222, 1'b1);
                2: drive(1'b1, 16'h3333, 1'b1);
                default: drive(1'b0, '0, 1'b1);
            endcase
            @(negedge clk);
            check("order_en", 32'(out_en), 32'(exp_e[i]));
            check("order_d",  32'(out_d),  32'(exp_d[i]));
        end

        // Fill past full with rd_ready low
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, DW'(16'h0100 + i), 1'b0);
            @(negedge clk);
            if (i == 4) check("af_below_thr", 32'(almost_full), 32'd0);
            if (i == 5) check("af_at_thr",    32'(almost_full), 32'd1);
            if (i == 6) check("full_at_7",    32'(full),        32'd0);
            if (i == 7) check("full_at_8",    32'(full),        32'd1);
            if (i == 7) check("ovf_before",   32'(overflow),    32'd0);
        end
        check("ovf_after_9th", 32'(overflow), 32'd1);
        check("count_full",    32'(count),    32'd8);
        drain(12, got);
        check("drain_len", 32'(got.size()), 32'd8);
        for (int k = 0; k < 8 && k < got.size(); k++)
            check("drain_word", 32'(got[k]), 32'(16'h0100 + k));
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Push and pop together while full
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, DW'(16'h0200 + i), 1'b0);
            @(negedge clk);
        end
        drive(1'b1, 16'hAAAA, 1'b1);
        @(negedge clk);
        check("fpp_count",  32'(count),    32'd8);
        check("fpp_ovf",    32'(overflow), 32'd0);
        check("fpp_out_d",  32'(out_d),    32'h0200);
        drain(12, got);
        check("fpp_len",    32'(got.size()), 32'd8);
        if (got.size() > 0) begin
            check("fpp_first", 32'(got[0]),            32'h0201);
            check("fpp_last",  32'(got[got.size()-1]), 32'hAAAA);
        end

        // Empty write-through latency
        do_reset();
        drive(1'b1, 16'h5A5A, 1'b1);
        @(negedge clk);
        check("byp_en_n1",    32'(out_en), BYP ? 32'd1 : 32'd0);
        check("byp_count_n1", 32'(count),  BYP ? 32'd0 : 32'd1);
        drive(1'b0, '0, 1'b1);
        @(negedge clk);
        check("byp_en_n2", 32'(out_en), BYP ? 32'd0 : 32'd1);
        check("byp_d_n2",  32'(out_d),  BYP ? 32'h0 : 32'h5A5A);

        // Randomized traffic against the model, with varying pressure
        do_reset();
        for (int i = 0; i < 600; i++) begin
            int wp = (i < 200) ? 70 : (i < 400) ? 40 : 55;
            int rp = (i < 200) ? 30 : (i < 400) ? 80 : 55;
            drive(($urandom_range(99) < wp), DW'($urandom), ($urandom_range(99) < rp));
            @(negedge clk);
            if (i == 300) begin
                rstn = 1'b0;
                @(negedge clk);
                rstn = 1'b1;
            end
        end
        drain(12, got);
        check("final_empty", 32'(empty), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
